// File: rtl/itch_mold_framer.sv
// rtl/itch_mold_framer.sv - MoldUDP64/ITCH frame parser emitting one wide left-aligned word per message
module itch_mold_framer #(
  parameter int HDR_BYTES     = 46,
  parameter int MAX_MSG_BYTES = 50,
  parameter int CNT_W         = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [7:0]                 in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic                       msg_valid,
  input  logic                       msg_ready,
  output logic [8*MAX_MSG_BYTES-1:0] msg_data,
  output logic [15:0]                msg_len,
  output logic [7:0]                 msg_type,
  output logic [63:0]                msg_seq,
  output logic [79:0]                session,
  output logic                       hb_pulse,
  output logic                       gap_pulse,
  output logic                       trunc_pulse,
  output logic [CNT_W-1:0]           oversize_cnt,
  output logic [CNT_W-1:0]           msg_cnt
);

  typedef enum logic [2:0] {
    S_HDR, S_MOLD, S_LEN_HI, S_LEN_LO, S_BODY, S_EMIT, S_DRAIN
  } state_t;

  state_t state, state_nx;

  logic [15:0]  byte_cnt;
  logic [15:0]  remaining;
  logic [151:0] mold_sh;
  logic [159:0] mold_full;
  logic [63:0]  mold_seq;
  logic [15:0]  mold_count;
  logic [63:0]  expected;
  logic         have_expected;
  logic [7:0]   len_hi;
  logic [15:0]  len_full;
  logic         drop;
  logic         last_seen;
  logic         beat, mold_done, is_hb, rem_last, body_final;
  logic         trunc_set, hb_set, gap_set;
  state_t       adv_state;
  logic         adv_trunc;

  assign in_ready   = (state != S_EMIT);
  assign msg_valid  = (state == S_EMIT);
  assign msg_type   = msg_data[8*MAX_MSG_BYTES-1 -: 8];
  assign beat       = in_valid & in_ready;
  assign mold_full  = {mold_sh, in_data};
  assign mold_seq   = mold_full[79:16];
  assign mold_count = mold_full[15:0];
  assign is_hb      = (mold_count == 16'h0000) || (mold_count == 16'hFFFF);
  assign mold_done  = beat && (state == S_MOLD) && (byte_cnt == 16'd19);
  assign len_full   = {len_hi, in_data};
  assign rem_last   = (remaining == 16'd1);
  assign body_final = (byte_cnt == msg_len - 16'd1);
  assign hb_set     = mold_done && is_hb;
  assign gap_set    = mold_done && have_expected && (mold_seq != expected);

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_HDR;
    else       state <= state_nx;
  end

  // Next state and truncation detection; a message that ends without being emitted advances via adv_*
  always_comb begin
    state_nx  = state;
    trunc_set = 1'b0;
    adv_state = S_LEN_HI;
    adv_trunc = 1'b0;
    if (rem_last) begin
      adv_state = in_last ? S_HDR : S_DRAIN;
    end else if (in_last) begin
      adv_state = S_HDR;
      adv_trunc = 1'b1;
    end
    case (state)
      S_HDR: if (beat) begin
        if (in_last) begin
          state_nx  = S_HDR;
          trunc_set = 1'b1;
        end else if (byte_cnt == 16'(HDR_BYTES - 1)) begin
          state_nx = S_MOLD;
        end
      end
      S_MOLD: if (beat) begin
        if (mold_done && is_hb) begin
          state_nx = in_last ? S_HDR : S_DRAIN;
        end else if (in_last) begin
          state_nx  = S_HDR;
          trunc_set = 1'b1;
        end else if (mold_done) begin
          state_nx = S_LEN_HI;
        end
      end
      S_LEN_HI: if (beat) begin
        state_nx  = in_last ? S_HDR : S_LEN_LO;
        trunc_set = in_last;
      end
      S_LEN_LO: if (beat) begin
        if (len_full == 16'd0) begin
          state_nx  = adv_state;
          trunc_set = adv_trunc;
        end else begin
          state_nx  = in_last ? S_HDR : S_BODY;
          trunc_set = in_last;
        end
      end
      S_BODY: if (beat) begin
        if (body_final && !drop) begin
          state_nx = S_EMIT;
        end else if (body_final) begin
          state_nx  = adv_state;
          trunc_set = adv_trunc;
        end else if (in_last) begin
          state_nx  = S_HDR;
          trunc_set = 1'b1;
        end
      end
      S_EMIT: if (msg_ready) begin
        if (last_seen) begin
          state_nx  = S_HDR;
          trunc_set = !rem_last;
        end else begin
          state_nx = rem_last ? S_DRAIN : S_LEN_HI;
        end
      end
      S_DRAIN: if (beat && in_last) state_nx = S_HDR;
      default: state_nx = S_HDR;
    endcase
  end

  // Datapath: header capture, sequence tracking, message assembly, pulses and counters
  always_ff @(posedge clk) begin
    if (reset) begin
      byte_cnt      <= '0;
      remaining     <= '0;
      mold_sh       <= '0;
      expected      <= '0;
      have_expected <= 1'b0;
      len_hi        <= '0;
      drop          <= 1'b0;
      last_seen     <= 1'b0;
      msg_data      <= '0;
      msg_len       <= '0;
      msg_seq       <= '0;
      session       <= '0;
      hb_pulse      <= 1'b0;
      gap_pulse     <= 1'b0;
      trunc_pulse   <= 1'b0;
      oversize_cnt  <= '0;
      msg_cnt       <= '0;
    end else begin
      hb_pulse    <= hb_set;
      gap_pulse   <= gap_set;
      trunc_pulse <= trunc_set;
      if (beat) byte_cnt <= (state_nx != state || in_last) ? 16'd0 : byte_cnt + 16'd1;
      case (state)
        S_MOLD: if (beat) begin
          mold_sh <= mold_full[151:0];
          if (mold_done) begin
            session       <= mold_full[159:80];
            expected      <= mold_seq + (is_hb ? 64'd0 : {48'd0, mold_count});
            have_expected <= 1'b1;
            msg_seq       <= mold_seq;
            remaining     <= mold_count;
          end
        end
        S_LEN_HI: if (beat) len_hi <= in_data;
        S_LEN_LO: if (beat) begin
          msg_len  <= len_full;
          drop     <= (len_full > 16'(MAX_MSG_BYTES));
          msg_data <= '0;
          if (len_full == 16'd0) begin
            msg_seq   <= msg_seq + 64'd1;
            remaining <= remaining - 16'd1;
          end
        end
        S_BODY: if (beat) begin
          for (int i = 0; i < MAX_MSG_BYTES; i++) begin
            if (byte_cnt == 16'(i)) msg_data[8*(MAX_MSG_BYTES-i)-1 -: 8] <= in_data;
          end
          if (body_final) begin
            last_seen <= in_last && !drop;
            if (drop) begin
              if (oversize_cnt != '1) oversize_cnt <= oversize_cnt + CNT_W'(1);
              msg_seq   <= msg_seq + 64'd1;
              remaining <= remaining - 16'd1;
            end
          end
        end
        S_EMIT: if (msg_ready) begin
          msg_cnt   <= msg_cnt + CNT_W'(1);
          msg_seq   <= msg_seq + 64'd1;
          remaining <= remaining - 16'd1;
          last_seen <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_itch_mold_framer.sv
// tb/tb_itch_mold_framer.sv - scoreboard testbench for itch_mold_framer
module tb_itch_mold_framer;
  localparam int MAXB = 50;
  localparam int DW   = 8 * MAXB;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    in_data;
  logic          in_valid, in_last, in_ready;
  logic          msg_valid, msg_ready;
  logic [DW-1:0] msg_data;
  logic [15:0]   msg_len;
  logic [7:0]    msg_type;
  logic [63:0]   msg_seq;
  logic [79:0]   session;
  logic          hb_pulse, gap_pulse, trunc_pulse;
  logic [15:0]   oversize_cnt, msg_cnt;

  itch_mold_framer #(.HDR_BYTES(46), .MAX_MSG_BYTES(MAXB), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .msg_len(msg_len), .msg_type(msg_type), .msg_seq(msg_seq), .session(session),
    .hb_pulse(hb_pulse), .gap_pulse(gap_pulse), .trunc_pulse(trunc_pulse),
    .oversize_cnt(oversize_cnt), .msg_cnt(msg_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    typ;
    logic [15:0]   len;
    logic [63:0]   seq;
    logic [DW-1:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  frame[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          stall_left = 0;
  int          hb_seen = 0, gap_seen = 0, trunc_seen = 0;
  logic [79:0] sess = 80'h5345_5353_494F_4E30_3031;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %0h required %0h", name, act, req);
    end
  endtask

  task automatic check_data(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  task automatic begin_frame(input logic [63:0] seq, input logic [15:0] cnt);
    frame.delete();
    for (int i = 0; i < 46; i++) frame.push_back(8'(i) ^ 8'hA5);
    for (int i = 9; i >= 0; i--) frame.push_back(sess[8*i +: 8]);
    for (int i = 7; i >= 0; i--) frame.push_back(seq[8*i +: 8]);
    frame.push_back(cnt[15:8]);
    frame.push_back(cnt[7:0]);
  endtask

  task automatic add_msg(input int len, input logic [7:0] typ, input int nsend,
                         input logic [63:0] seq, input bit emit);
    exp_t        e;
    logic [7:0]  b;
    logic [15:0] l16;
    l16 = 16'(len);
    frame.push_back(l16[15:8]);
    frame.push_back(l16[7:0]);
    e.typ  = typ;
    e.len  = l16;
    e.seq  = seq;
    e.data = '0;
    for (int k = 0; k < nsend; k++) begin
      b = (k == 0) ? typ : 8'(k * 3 + 1);
      frame.push_back(b);
      if (k < MAXB) e.data[DW-1-8*k -: 8] = b;
    end
    if (emit) exp_q.push_back(e);
  endtask

  task automatic send_frame(input int stall, input int nbytes);
    int n;
    int w;
    n = (nbytes < 0) ? frame.size() : nbytes;
    stall_left = stall;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_data  = frame[i];
      in_valid = 1'b1;
      in_last  = (i == frame.size() - 1);
      w = 0;
      while (!in_ready && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (w >= 200) begin
        n_cmp++;
        n_bad++;
        $display("FAIL in_ready_timeout: actual in_ready=0 for 200 cycles at byte %0d required 1", i);
        break;
      end
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic settle(input string tag, input int e_hb, input int e_gap, input int e_trunc,
                        input int e_cnt, input int e_ovs);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check({tag, "_pending_msgs"}, exp_q.size(), 0);
    check({tag, "_hb_cycles"}, hb_seen, e_hb);
    check({tag, "_gap_cycles"}, gap_seen, e_gap);
    check({tag, "_trunc_cycles"}, trunc_seen, e_trunc);
    check({tag, "_msg_cnt"}, msg_cnt, e_cnt);
    check({tag, "_oversize_cnt"}, oversize_cnt, e_ovs);
    hb_seen = 0;
    gap_seen = 0;
    trunc_seen = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    hb_seen = 0;
    gap_seen = 0;
    trunc_seen = 0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_msg_valid"}, msg_valid, 0);
    check({tag, "_msg_cnt"}, msg_cnt, 0);
    check({tag, "_oversize_cnt"}, oversize_cnt, 0);
    check({tag, "_msg_seq"}, msg_seq, 0);
    check({tag, "_msg_len"}, msg_len, 0);
    check({tag, "_msg_type"}, msg_type, 0);
    check({tag, "_session"}, session, 0);
    check({tag, "_pulses"}, {hb_pulse, gap_pulse, trunc_pulse}, 0);
    check_data({tag, "_msg_data"}, msg_data, '0);
  endtask

  // Monitor: counts pulse cycles, applies back-pressure, and scores each handshaked message
  initial begin : monitor
    exp_t e;
    msg_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (hb_pulse) hb_seen++;
      if (gap_pulse) gap_seen++;
      if (trunc_pulse) trunc_seen++;
      if (!reset && msg_valid) begin
        if (exp_q.size() == 0) begin
          msg_ready = 1'b1;
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_msg: actual seq %0d type %0h required no message", msg_seq, msg_type);
        end else if (stall_left > 0) begin
          msg_ready = 1'b0;
          stall_left--;
          e = exp_q[0];
          check("stall_in_ready", in_ready, 0);
          check("stall_msg_len", msg_len, e.len);
          check("stall_msg_seq", msg_seq, e.seq);
          check_data("stall_msg_data", msg_data, e.data);
        end else begin
          msg_ready = 1'b1;
          e = exp_q.pop_front();
          check("msg_type", msg_type, e.typ);
          check("msg_len", msg_len, e.len);
          check("msg_seq", msg_seq, e.seq);
          check_data("msg_data", msg_data, e.data);
        end
      end else begin
        msg_ready = 1'b1;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: actual run still active at 1ms required finished");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : stimulus
    reset    = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_idle("reset0");

    begin_frame(64'd100, 16'd2);
    add_msg(12, 8'h53, 12, 64'd100, 1'b1);
    add_msg(39, 8'h52, 39, 64'd101, 1'b1);
    send_frame(0, -1);
    settle("t1", 0, 0, 0, 2, 0);
    check("t1_session", session, sess);
    check("t1_next_seq", msg_seq, 64'd102);

    begin_frame(64'd102, 16'd2);
    add_msg(12, 8'h53, 12, 64'd102, 1'b1);
    add_msg(39, 8'h52, 39, 64'd103, 1'b1);
    send_frame(5, -1);
    settle("t2", 0, 0, 0, 4, 0);

    begin_frame(64'd7, 16'hFFFF);
    send_frame(0, -1);
    settle("t3_hb", 1, 1, 0, 4, 0);
    begin_frame(64'd7, 16'd1);
    add_msg(12, 8'h53, 12, 64'd7, 1'b1);
    send_frame(0, -1);
    settle("t3_data", 0, 0, 0, 5, 0);

    do_reset();
    check_idle("reset1");
    begin_frame(64'd10, 16'd3);
    add_msg(12, 8'h41, 12, 64'd10, 1'b1);
    add_msg(20, 8'h46, 20, 64'd11, 1'b1);
    add_msg(12, 8'h45, 12, 64'd12, 1'b1);
    send_frame(0, -1);
    settle("t4a", 0, 0, 0, 3, 0);
    check("t4a_next_seq", msg_seq, 64'd13);
    begin_frame(64'd14, 16'd1);
    add_msg(12, 8'h55, 12, 64'd14, 1'b1);
    frame.push_back(8'h00);
    frame.push_back(8'h00);
    send_frame(0, -1);
    settle("t4b", 0, 1, 0, 4, 0);

    begin_frame(64'd1, 16'd3);
    add_msg(12, 8'h53, 12, 64'd1, 1'b1);
    add_msg(60, 8'h58, 60, 64'd2, 1'b0);
    add_msg(12, 8'h50, 12, 64'd3, 1'b1);
    send_frame(0, -1);
    settle("t5", 0, 1, 0, 6, 1);

    begin_frame(64'd4, 16'd1);
    add_msg(12, 8'h53, 5, 64'd4, 1'b0);
    send_frame(0, -1);
    settle("t6_trunc", 0, 0, 1, 6, 1);
    begin_frame(64'd20, 16'd1);
    send_frame(0, 10);
    do_reset();
    check_idle("reset2");
    begin_frame(64'd50, 16'd1);
    add_msg(12, 8'h41, 12, 64'd50, 1'b1);
    send_frame(0, -1);
    settle("t6_after", 0, 0, 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/itch_mold_framer.md
Name: itch_mold_framer

Overview:
- Parametrised successor to the fixed-width, byte-per-clock ITCH decoder.
- Accepts a valid/ready byte stream of whole Ethernet frames and skips a configurable L2–L4 header.
- Parses the MoldUDP64 header, then splits the payload into ITCH messages using each message's 2-byte length prefix.
- Emits every message as one wide, left-aligned word with its sequence number over a valid/ready interface, and feeds the per-type decoders downstream.

Parameters:
- HDR_BYTES, 46: bytes skipped before the MoldUDP64 header (Ethernet + VLAN + EtherType + IPv4 + UDP).
- MAX_MSG_BYTES, 50: largest message emitted; sets msg_data width.
- CNT_W, 16: width of the statistic counters.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- in_data  in  8  frame byte.
- in_valid  in  1  byte valid.
- in_last  in  1  final byte of frame.
- in_ready  out  1  byte accepted when in_valid & in_ready.
- msg_valid  out  1  message available.
- msg_ready  in  1  downstream accepts message.
- msg_data  out  8*MAX_MSG_BYTES  message body; byte 0 (type) at MSBs, unused bytes zero.
- msg_len  out  16  message length in bytes.
- msg_type  out  8  first message byte.
- msg_seq  out  64  MoldUDP64 sequence number of this message.
- session  out  80  session of the current packet.
- hb_pulse  out  1  one-cycle pulse per heartbeat/end-of-session packet.
- gap_pulse  out  1  one-cycle pulse when packet seq differs from expected.
- trunc_pulse  out  1  one-cycle pulse when in_last arrives before the payload is complete.
- oversize_cnt  out  CNT_W  messages dropped for len > MAX_MSG_BYTES; saturating.
- msg_cnt  out  CNT_W  messages emitted; wraps.

Behaviour:
- Beat = in_valid & in_ready. in_ready = 1 in every state except EMIT.
- States: HDR, MOLD, LEN_HI, LEN_LO, BODY, EMIT, DRAIN.
- Reset (from any state, mid-frame included):
  - state = HDR; all outputs, counters, msg_data and the expected-seq register = 0.
  - have_expected = 0; the partial frame is discarded.
- HDR: count HDR_BYTES beats, then go to MOLD.
- MOLD: 20 beats, MSB first: session (10 bytes), seq (8), count (2). On the 20th beat:
  - Gap check: if have_expected and seq != expected, pulse gap_pulse. Then set expected = seq + count (count = 0 for heartbeats) and have_expected = 1.
  - count == 0xFFFF or 0: pulse hb_pulse and go to DRAIN.
  - Otherwise: go to LEN_HI; cur_seq = seq; remaining = count.
- LEN_HI / LEN_LO: length big-endian.
  - len == 0: cur_seq++, remaining--, then go to LEN_HI, or DRAIN if remaining reaches 0.
  - len > MAX_MSG_BYTES: set drop flag.
  - msg_data is cleared on LEN_LO.
- BODY: byte i is written to msg_data[8*(MAX_MSG_BYTES-i)-1 -: 8] when i < MAX_MSG_BYTES. On the len-th byte:
  - No drop flag: go to EMIT.
  - Drop flag: oversize_cnt++; cur_seq++; remaining--; go to LEN_HI or DRAIN.
- EMIT: msg_valid = 1 with msg_len, msg_type, msg_seq = cur_seq; outputs are held stable until msg_ready. On handshake:
  - msg_valid drops the next cycle.
  - msg_cnt++, cur_seq++, remaining--.
  - Next state: HDR if the frame's in_last was already consumed; else LEN_HI if remaining != 0; else DRAIN.
- DRAIN: discard beats until in_last, then go to HDR.
- in_last in any state other than DRAIN, and not on the final body byte of the last message:
  - pulse trunc_pulse; drop the partial message; go to HDR.
  - If that byte completes a message with remaining > 1, the message is still emitted, then trunc_pulse fires and the block returns to HDR.
- All pulses last exactly one cycle. Latency from the last message byte to msg_valid: 1 cycle.
- Simultaneous events: gap_pulse and hb_pulse may assert in the same cycle. Counters saturate (oversize) or wrap (msg_cnt) at 2^CNT_W-1.

Test Plan:
- Frame, seq = 100, count = 2: a 12-byte "S" message then a 39-byte "R" message, msg_ready = 1.
  -> Two msg_valid cycles: first has msg_type = 0x53, msg_len = 12, msg_seq = 100, bytes 12+ zero; second has 0x52, 39, 101. msg_cnt = 2.
- Same frame with msg_ready low for 5 cycles during the first EMIT.
  -> msg_data, msg_seq and msg_len stable throughout; in_ready = 0; no byte lost; second message seq = 101.
- count = 0xFFFF heartbeat followed by a data frame, seq = 7, count = 1.
  -> hb_pulse once; no msg_valid for the heartbeat; data message emitted with msg_seq = 7; gap_pulse only if expected != 7.
- Frame A (seq 10, count 3) then frame B (seq 14).
  -> gap_pulse on B's 20th Mold byte; frame A expected 13 and messages emit normally.
- Message with len = 60 (MAX 50) between two 12-byte messages, seq 1 / 2 / 3.
  -> oversize_cnt = 1; emitted msg_seq values 1 and 3.
- in_last on the 5th body byte of a 12-byte message, then reset asserted mid-HDR of the next frame.
  -> trunc_pulse once; no msg_valid; after reset all outputs = 0 and the next complete frame parses correctly.
